// File: rtl/input_ctrl_pkg.sv
// Shared register map and helpers for the switch/button input peripheral.
package input_ctrl_pkg;

  localparam logic [7:0] ADDR_SW      = 8'h00;
  localparam logic [7:0] ADDR_BTN     = 8'h10;
  localparam logic [7:0] ADDR_BTN_EVT = 8'h14;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h18;
  localparam logic [7:0] ADDR_SW_CHG  = 8'h1C;

  // Width of the debounce counter; it only has to reach DB_CYCLES-1.
  function automatic int db_cnt_w(input int db_cycles);
    return (db_cycles <= 2) ? 1 : $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/input_ctrl_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter and accepted-state flop.
// dout changes DB_CYCLES clocks after the synchronised input settles; rise pulses in the cycle before stable goes 0->1.
module debounce_ch
  import input_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int            CW       = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // The clear at CNT_LAST keeps the counter from ever wrapping.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = stable;
  assign rise = accept & sync2;

endmodule

// File: rtl/input_ctrl.sv
// Memory-mapped switch/button input block with sticky W1C event flags and a maskable level irq.
// Reads are combinational from registered state; writes land on the clock edge with we=1, no stalls.
module input_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int SW_W      = 32,
  parameter int BTN_N     = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic [SW_W-1:0]  io_sw,
  input  logic [BTN_N-1:0] io_btn,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [SW_W-1:0]  sw_s1;
  logic [SW_W-1:0]  sw_q;
  logic [SW_W-1:0]  sw_prev;
  logic [BTN_N-1:0] btn_stable;
  logic [BTN_N-1:0] btn_rise;
  logic [BTN_N-1:0] btn_evt;
  logic [BTN_N-1:0] irq_en;
  logic [BTN_N-1:0] evt_clr;
  logic             sw_chg;
  logic             chg_clr;
  logic             unused_wdata;

  for (genvar i = 0; i < BTN_N; i++) begin : g_btn
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (io_btn[i]),
      .dout(btn_stable[i]),
      .rise(btn_rise[i])
    );
  end

  assign evt_clr      = (we && addr == ADDR_BTN_EVT) ? wdata[BTN_N-1:0] : '0;
  assign chg_clr      = we && (addr == ADDR_SW_CHG) && wdata[0];
  assign unused_wdata = ^wdata;

  // Set terms are OR-ed after the clear so a same-cycle event survives a W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_q    <= '0;
      sw_prev <= '0;
      btn_evt <= '0;
      irq_en  <= '0;
      sw_chg  <= 1'b0;
    end else begin
      sw_s1   <= io_sw;
      sw_q    <= sw_s1;
      sw_prev <= sw_q;
      btn_evt <= (btn_evt & ~evt_clr) | btn_rise;
      sw_chg  <= (sw_chg & ~chg_clr) | (sw_q != sw_prev);
      if (we && addr == ADDR_IRQ_EN) irq_en <= wdata[BTN_N-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_SW:      rdata[SW_W-1:0]  = sw_q;
      ADDR_BTN:     rdata[BTN_N-1:0] = btn_stable;
      ADDR_BTN_EVT: rdata[BTN_N-1:0] = btn_evt;
      ADDR_IRQ_EN:  rdata[BTN_N-1:0] = irq_en;
      ADDR_SW_CHG:  rdata[0]         = sw_chg;
      default:      rdata            = '0;
    endcase
  end

  assign irq = |(btn_evt & irq_en);

endmodule

// File: tb/tb_input_ctrl.sv
// Bench for input_ctrl with DB_CYCLES=4: directed scenarios plus random traffic against a history-based model.
module tb_input_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = 8'h00;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] io_sw = 32'h0;
  logic [3:0]  io_btn = 4'h0;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  input_ctrl #(
    .SW_W     (32),
    .BTN_N    (4),
    .DB_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .io_sw (io_sw),
    .io_btn(io_btn),
    .rdata (rdata),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  // Reference model: a button is accepted once its synchronised value has
  // disagreed with the accepted state for the last DB consecutive samples.
  logic [31:0] m_sw_s1, m_sw_q, m_sw_prev;
  logic [3:0]  m_btn_s1, m_btn_s, m_stable, m_evt, m_en, m_rise, m_clr;
  logic        m_chg, m_all;
  logic [3:0]  hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_sw_s1 = '0; m_sw_q = '0; m_sw_prev = '0;
      m_btn_s1 = '0; m_btn_s = '0; m_stable = '0;
      m_evt = '0; m_en = '0; m_chg = 1'b0;
      hist.delete();
    end else begin
      m_rise = '0;
      hist.push_back(m_btn_s);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        for (int i = 0; i < 4; i++) begin
          m_all = 1'b1;
          foreach (hist[j]) if (hist[j][i] == m_stable[i]) m_all = 1'b0;
          if (m_all) begin
            m_stable[i] = ~m_stable[i];
            m_rise[i]   = m_stable[i];
          end
        end
      end
      m_clr = (we && addr == 8'h14) ? wdata[3:0] : 4'h0;
      m_evt = (m_evt & ~m_clr) | m_rise;
      m_chg = (m_chg & ~(we && addr == 8'h1C && wdata[0])) | (m_sw_q != m_sw_prev);
      if (we && addr == 8'h18) m_en = wdata[3:0];
      m_sw_prev = m_sw_q;
      m_sw_q    = m_sw_s1;
      m_sw_s1   = io_sw;
      m_btn_s   = m_btn_s1;
      m_btn_s1  = io_btn;
    end
  end

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    case (a)
      8'h00:   return m_sw_q;
      8'h10:   return {28'h0, m_stable};
      8'h14:   return {28'h0, m_evt};
      8'h18:   return {28'h0, m_en};
      8'h1C:   return {31'h0, m_chg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset;
    logic [7:0] amap [6] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C};
    rst = 1'b1; io_sw = 32'hFFFF_FFFF; io_btn = 4'hF;
    repeat (3) @(negedge clk);
    foreach (amap[k]) begin
      addr = amap[k]; #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++; $display("FAIL reset_read addr=%h: got %h want 0", amap[k], rdata);
      end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0; io_btn = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      addr = 8'h00; #1;
      checks++;
      if (rdata !== (k >= 2 ? 32'hFFFF_FFFF : 32'h0)) begin
        errors++; $display("FAIL sw_latency clk%0d: got %h want %h", k, rdata, (k >= 2 ? 32'hFFFF_FFFF : 32'h0));
      end
      addr = 8'h1C; #1;
      checks++;
      if (rdata !== (k >= 3 ? 32'h1 : 32'h0)) begin
        errors++; $display("FAIL sw_chg_set clk%0d: got %h want %h", k, rdata, (k >= 3 ? 32'h1 : 32'h0));
      end
    end
    we = 1'b1; addr = 8'h1C; wdata = 32'h1;
    @(negedge clk);
    we = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL sw_chg_w1c: got %h want 0", rdata); end
  endtask

  task automatic test_bounce;
    @(negedge clk);
    io_btn = 4'b0001;
    repeat (3) @(negedge clk);
    io_btn = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      addr = 8'h10; #1;
      checks++;
      if (rdata !== 32'h0 || rdata !== model_rd(8'h10)) begin
        errors++; $display("FAIL bounce_btn cyc%0d: got %h want 0", k, rdata);
      end
      addr = 8'h14; #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL bounce_evt cyc%0d: got %h want 0", k, rdata); end
    end
  endtask

  task automatic test_press;
    we = 1'b1; addr = 8'h18; wdata = 32'h4;
    @(negedge clk);
    we = 1'b0;
    io_btn = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      addr = 8'h10; #1;
      checks++;
      if (rdata !== (k == 6 ? 32'h4 : 32'h0)) begin
        errors++; $display("FAIL press_btn clk%0d: got %h want %h", k, rdata, (k == 6 ? 32'h4 : 32'h0));
      end
      addr = 8'h14; #1;
      checks++;
      if (rdata !== (k == 6 ? 32'h4 : 32'h0)) begin
        errors++; $display("FAIL press_evt clk%0d: got %h want %h", k, rdata, (k == 6 ? 32'h4 : 32'h0));
      end
      checks++;
      if (irq !== (k == 6)) begin errors++; $display("FAIL press_irq clk%0d: got %b want %b", k, irq, (k == 6)); end
    end
  endtask

  task automatic test_w1c;
    we = 1'b1; addr = 8'h14; wdata = 32'h4; #1;
    checks++;
    if (rdata !== 32'h4) begin errors++; $display("FAIL w1c_prewrite: got %h want 4", rdata); end
    @(negedge clk);
    we = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL w1c_evt: got %h want 0", rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
    addr = 8'h10; #1;
    checks++;
    if (rdata !== 32'h4) begin errors++; $display("FAIL w1c_btn: got %h want 4", rdata); end
  endtask

  task automatic test_collision;
    io_btn = 4'b0110;
    repeat (5) @(negedge clk);
    // The rise of button 1 lands on the next edge, together with the W1C.
    we = 1'b1; addr = 8'h14; wdata = 32'h2;
    @(negedge clk);
    we = 1'b0; #1;
    checks++;
    if (rdata !== 32'h2) begin errors++; $display("FAIL collision_evt: got %h want 2", rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL collision_irq: got %b want 0", irq); end
    addr = 8'h10; #1;
    checks++;
    if (rdata !== 32'h6) begin errors++; $display("FAIL collision_btn: got %h want 6", rdata); end
  endtask

  task automatic test_reset_mid;
    io_btn = 4'b0000;
    repeat (8) @(negedge clk);
    io_btn = 4'b1000;
    repeat (4) @(negedge clk);   // synchronised and two counts into the debounce
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      addr = 8'h10; #1;
      checks++;
      if (rdata !== (k == 6 ? 32'h8 : 32'h0)) begin
        errors++; $display("FAIL rst_mid_btn clk%0d: got %h want %h", k, rdata, (k == 6 ? 32'h8 : 32'h0));
      end
    end
    addr = 8'h04; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", rdata); end
    addr = 8'h18; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rst_irq_en: got %h want 0", rdata); end
  endtask

  task automatic test_random;
    logic [7:0] amap [7] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h00};
    logic [7:0] ra;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      we = 1'b0;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) io_sw = $urandom;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) io_btn[b] = ~io_btn[b];
      ra = amap[$urandom_range(0, 5)];
      addr = ra; #1;
      checks++;
      if (rdata !== model_rd(ra)) begin
        errors++; $display("FAIL rand_read n=%0d addr=%h: got %h want %h", n, ra, rdata, model_rd(ra));
      end
      checks++;
      if (irq !== |(m_evt & m_en)) begin
        errors++; $display("FAIL rand_irq n=%0d: got %b want %b", n, irq, |(m_evt & m_en));
      end
      ra = ($urandom_range(0, 6) == 6) ? 8'($urandom) : amap[$urandom_range(0, 5)];
      addr  = ra;
      wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'hF;
      we    = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (rdata !== model_rd(ra)) begin
        errors++; $display("FAIL rand_op_read n=%0d addr=%h: got %h want %h", n, ra, rdata, model_rd(ra));
      end
    end
    @(negedge clk);
    we = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press();
    test_w1c();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_ctrl.md
# input_ctrl

Parametrised, clocked input peripheral for the single-cycle core's memory-mapped I/O space. It samples the board switches and push-buttons through 2-flop synchronisers and debounces each button with its own counter. It latches button-press events in sticky, write-1-to-clear flags and raises a maskable level interrupt. Reads stay combinational from registered state, so a load completes in the same cycle as on the core's other peripherals.

## Interface
- `SW_W`, default 32: switch channel count, ≤ 32.
- `BTN_N`, default 4: button channel count, ≤ 32.
- `DB_CYCLES`, default 16: consecutive stable cycles needed to accept a button change, ≥ 2.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `addr`  in  8: byte offset inside the peripheral window.
- `we`  in  1: write strobe, qualified with `addr`.
- `wdata`  in  32: write data.
- `io_sw`  in  SW_W: raw switch inputs, asynchronous.
- `io_btn`  in  BTN_N: raw button inputs, asynchronous, active-high.
- `rdata`  out  32: read data, combinational from `addr`.
- `irq`  out  1: level interrupt, `|(btn_evt & irq_en)`.

## Operation
- Register map uses a full 8-bit compare; unmapped reads return 0 and unmapped writes are ignored. Narrow fields are zero-extended.
  - 0x00 SW (RO): synchronised switch state.
  - 0x10 BTN (RO): debounced button state.
  - 0x14 BTN_EVT (RW1C): sticky rising-edge flags, one per button.
  - 0x18 IRQ_EN (RW): per-button interrupt mask, BTN_N bits.
  - 0x1C SW_CHG (RW1C): bit 0 is sticky, set when any synchronised switch bit changes.
- **Switch path:** 2-flop synchroniser into `sw_q`. `SW_CHG` sets when `sw_q` differs from its previous-cycle value.
- **Button path:** 2-flop synchroniser gives `btn_s`, then a per-channel counter of width `$clog2(DB_CYCLES)`.
  - `btn_s == stable`: counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals `DB_CYCLES-1` and `btn_s` still differs: `stable <= btn_s` and the counter clears.
  - The counter never wraps.
- **Events:** a 0→1 transition of `stable` sets `BTN_EVT[i]`. A write to 0x14 with `wdata[i]=1` clears it.
  - If a set and a clear hit the same bit in the same cycle, the set wins. SW_CHG follows the same rule.
- **Writes:** a write to IRQ_EN takes `wdata[BTN_N-1:0]`. Writes to RO addresses are ignored.
- **Reset:** applies in the clock edge where `rst=1`. It zeroes all of the following:
  - synchronisers, counters, `stable`, `sw_q`
  - BTN_EVT, SW_CHG, IRQ_EN
  - consequently `irq=0` and every register reads 0
- **Reset mid-debounce:** discards the partial count. The channel restarts from 0 after reset is released.

## Timing
- Switch input change to SW register: visible 2 clocks later. SW_CHG sets 1 clock after that.
- Button input held steady to BTN: changes after 2 + `DB_CYCLES` clocks.
  - A glitch of fewer than `DB_CYCLES` cycles at `btn_s` produces no change.
- BTN_EVT sets in the same edge as BTN rises. `irq` follows combinationally from the flag registers, so it asserts in that cycle if enabled.
- `rdata` is combinational in `addr` and register state, with no read side effects.
- Writes take effect at the clock edge where `we=1`. A read in that same cycle returns the pre-write value.

## Structure
- Package `input_ctrl_pkg` holds:
  - address localparams `ADDR_SW`, `ADDR_BTN`, `ADDR_BTN_EVT`, `ADDR_IRQ_EN`, `ADDR_SW_CHG`
  - the counter-width function
- Sub-module `debounce_ch` (parameter `DB_CYCLES`; ports `clk`, `rst`, `din`, `dout`, `rise`) contains one synchroniser, counter and stable flop. It is instantiated `BTN_N` times via generate.
- Top level contains the switch synchronisers, sticky flags, IRQ_EN, read mux and `irq` OR-reduction.

## Test plan
All scenarios use `DB_CYCLES=4`.
1. **Reset:** `rst=1` with `io_sw=32'hFFFF_FFFF`, `io_btn=4'hF`. Every address reads 0 and `irq=0`. Release `rst`: SW reads `32'hFFFF_FFFF` 2 clocks later and SW_CHG reads 1.
2. **Bounce reject:** `io_btn[0]` pulses high for 3 cycles. BTN stays 0 and BTN_EVT stays 0.
3. **Clean press:** `io_btn[2]` held high, IRQ_EN=`4'b0100`.
   - BTN reads `4'b0100` after 6 clocks.
   - BTN_EVT reads `4'b0100` and `irq=1` in that same cycle.
4. **W1C:** write `32'h4` to 0x14. BTN_EVT reads 0 and `irq=0` next cycle. BTN still reads `4'b0100`.
5. **Clear collision:** W1C of bit 1 lands in the same cycle a new rising edge on button 1 sets it. BTN_EVT[1] reads 1 afterwards.
6. **Reset mid-debounce:** assert `rst` 2 cycles into a press, then release.
   - Counter restarts from 0.
   - BTN rises exactly 6 clocks after release with the button still held.
   - Unmapped address 0x04 reads 0.
